serial_word_comparator: RTL and testbench

- Multi-cycle equality comparator for WIDTH-bit words. It processes one 2-bit pair per clock and consumes the existing 2-bit equality cell (comparator2bit: z=1 iff x==y).
- Sits downstream of operand registers and upstream of match/status logic.
- Reports overall equality, the index of the first mismatching pair, and the number of mismatching pairs.
- Uses a start/busy/done handshake so a small datapath serves wide operands.

---
 rtl/serial_word_comparator_pkg.sv | 31 +++
 rtl/serial_word_comparator_cmp2.sv | 13 +
 rtl/serial_word_comparator.sv | 116 +++++++++++
 tb/tb_serial_word_comparator.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/serial_word_comparator_pkg.sv
// Purpose : shared state encoding and elaboration helpers for the serial word comparator.
// Latency : n/a (types and constant functions only).
// Backpressure: n/a.
`ifndef SERIAL_WORD_COMPARATOR_PKG_SV
`define SERIAL_WORD_COMPARATOR_PKG_SV

package serial_word_comparator_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Ceiling log2 for elaboration-time width math; returns at least 1 so that
    // an index bus never collapses to zero bits.
    function automatic int sw_clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result = result + 1;
        end
        if (result < 1) begin
            result = 1;
        end
        return result;
    endfunction

endpackage

`endif

// File: rtl/serial_word_comparator_cmp2.sv
// Purpose : 2-bit equality cell, z=1 iff x==y.
// Latency : combinational.
// Backpressure: none.
// Ports   : x, y - 2-bit operands; z - equality flag.
module comparator2bit (
    input  logic [1:0] x,
    input  logic [1:0] y,
    output logic       z
);

    assign z = (x == y);

endmodule

// File: rtl/serial_word_comparator.sv
// Purpose : multi-cycle WIDTH-bit equality compare, one 2-bit pair per clock.
// Latency : start accepted on E0, done pulses in the cycle after E(NPAIR).
// Backpressure: start is ignored while busy; accepted only in IDLE or DONE.
// Ports   : clk/rst (async active-high); start, a, b in; busy, done, equal,
//           first_diff (lowest mismatching pair), diff_count (mismatching pairs) out.
module serial_word_comparator
    import serial_word_comparator_pkg::*;
#(
    parameter  int WIDTH = 8,
    localparam int NPAIR = WIDTH / 2,
    localparam int IDX_W = sw_clog2(NPAIR)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             equal,
    output logic [IDX_W-1:0] first_diff,
    output logic [IDX_W:0]   diff_count
);

    localparam logic [IDX_W-1:0] LAST_PIDX = IDX_W'(NPAIR - 1);

    if ((WIDTH % 2) != 0 || WIDTH < 4) begin : g_bad_width
        $error("serial_word_comparator: WIDTH must be even and >= 4");
    end

    state_t             state_q;
    state_t             state_d;
    logic [WIDTH-1:0]   sa;
    logic [WIDTH-1:0]   sb;
    logic [IDX_W-1:0]   pidx;
    logic [IDX_W:0]     acc_cnt;
    logic [IDX_W-1:0]   acc_first;
    logic               seen;
    logic               pair_eq;
    logic               accept;
    logic               last_pair;
    logic [IDX_W:0]     cnt_next;
    logic [IDX_W-1:0]   first_next;

    comparator2bit u_cmp2 (
        .x (sa[1:0]),
        .y (sb[1:0]),
        .z (pair_eq)
    );

    // Operands are only taken when the engine is free: IDLE, or DONE for back-to-back.
    assign accept    = start && (state_q == IDLE || state_q == DONE);
    assign last_pair = (pidx == LAST_PIDX);

    // Accumulator values including the pair currently on the comparator, so the
    // final edge can publish results that already account for the last pair.
    assign cnt_next   = acc_cnt + {{IDX_W{1'b0}}, ~pair_eq};
    assign first_next = (!pair_eq && !seen) ? pidx : acc_first;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (last_pair) state_d = DONE;
            DONE:    state_d = start ? RUN : IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign busy = (state_q == RUN);
    assign done = (state_q == DONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sa         <= '0;
            sb         <= '0;
            pidx       <= '0;
            acc_cnt    <= '0;
            acc_first  <= '0;
            seen       <= 1'b0;
            equal      <= 1'b0;
            first_diff <= '0;
            diff_count <= '0;
        end else if (accept) begin
            sa        <= a;
            sb        <= b;
            pidx      <= '0;
            acc_cnt   <= '0;
            acc_first <= '0;
            seen      <= 1'b0;
        end else if (state_q == RUN) begin
            sa        <= {2'b00, sa[WIDTH-1:2]};
            sb        <= {2'b00, sb[WIDTH-1:2]};
            acc_cnt   <= cnt_next;
            acc_first <= first_next;
            seen      <= seen | ~pair_eq;
            if (last_pair) begin
                // Results stay put until the next completion; a new start does not clear them.
                equal      <= (cnt_next == '0);
                first_diff <= first_next;
                diff_count <= cnt_next;
            end else begin
                pidx <= pidx + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_serial_word_comparator.sv
module tb_serial_word_comparator;

    localparam int WIDTH = 8;
    localparam int NPAIR = WIDTH / 2;
    localparam int IDX_W = 2;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             start = 1'b0;
    logic [WIDTH-1:0] a = '0;
    logic [WIDTH-1:0] b = '0;
    logic             busy;
    logic             done;
    logic             equal;
    logic [IDX_W-1:0] first_diff;
    logic [IDX_W:0]   diff_count;

    int errors = 0;
    int checks = 0;

    serial_word_comparator #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .a          (a),
        .b          (b),
        .busy       (busy),
        .done       (done),
        .equal      (equal),
        .first_diff (first_diff),
        .diff_count (diff_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int actual, input int expected);
        checks = checks + 1;
        if (actual != expected) begin
            errors = errors + 1;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Whole-word result computed directly from the operand values.
    int m_eq, m_first, m_cnt;
    task automatic calc(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                        output int eq, output int first, output int cnt);
        cnt = 0;
        first = 0;
        for (int i = NPAIR - 1; i >= 0; i--) begin
            if (x[2*i +: 2] != y[2*i +: 2]) begin
                cnt = cnt + 1;
                first = i;
            end
        end
        eq = (cnt == 0) ? 1 : 0;
    endtask

    // Timing model in terms of edge numbers: an accept on edge n gives busy
    // after edges n..n+NPAIR-1, done after edge n+NPAIR, next accept from n+NPAIR+1.
    int edge_n    = 0;
    int acc_edge  = -1;
    int free_edge = 0;
    int pend_eq = 0, pend_first = 0, pend_cnt = 0;
    int exp_eq = 0, exp_first = 0, exp_cnt = 0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_edge  = -1;
            free_edge = 0;
            exp_eq    = 0;
            exp_first = 0;
            exp_cnt   = 0;
        end else begin
            edge_n = edge_n + 1;
            if (acc_edge >= 0 && edge_n == acc_edge + NPAIR) begin
                exp_eq    = pend_eq;
                exp_first = pend_first;
                exp_cnt   = pend_cnt;
            end
            if (start && edge_n >= free_edge) begin
                acc_edge  = edge_n;
                free_edge = edge_n + NPAIR + 1;
                calc(a, b, m_eq, m_first, m_cnt);
                pend_eq    = m_eq;
                pend_first = m_first;
                pend_cnt   = m_cnt;
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(posedge clk) begin
        int exp_busy, exp_done;
        #1;
        exp_busy = (acc_edge >= 0 && edge_n >= acc_edge && edge_n < acc_edge + NPAIR) ? 1 : 0;
        exp_done = (acc_edge >= 0 && edge_n == acc_edge + NPAIR) ? 1 : 0;
        if (rst) begin
            exp_busy = 0;
            exp_done = 0;
        end
        chk("cyc_busy", int'(busy), exp_busy);
        chk("cyc_done", int'(done), exp_done);
        chk("cyc_equal", int'(equal), exp_eq);
        chk("cyc_first_diff", int'(first_diff), exp_first);
        chk("cyc_diff_count", int'(diff_count), exp_cnt);
    end

    // ---------------- directed stimulus ----------------
    task automatic check_result(input string tag, input int eq, input int first, input int cnt);
        chk({tag, "_equal"}, int'(equal), eq);
        chk({tag, "_first_diff"}, int'(first_diff), first);
        chk({tag, "_diff_count"}, int'(diff_count), cnt);
        chk({tag, "_model_equal"}, exp_eq, eq);
        chk({tag, "_model_first"}, exp_first, first);
        chk({tag, "_model_count"}, exp_cnt, cnt);
    endtask

    task automatic run_one(input string tag, input logic [WIDTH-1:0] va, input logic [WIDTH-1:0] vb,
                           input int eq, input int first, input int cnt);
        int nbusy;
        int got;
        @(negedge clk);
        start = 1'b1;
        a = va;
        b = vb;
        @(negedge clk);
        start = 1'b0;
        a = ~va;
        b = vb ^ 8'h3C;
        nbusy = 0;
        got = 0;
        for (int i = 0; i < 20; i++) begin
            if (done) begin
                got = 1;
                break;
            end
            if (busy) nbusy = nbusy + 1;
            @(negedge clk);
        end
        chk({tag, "_done_seen"}, got, 1);
        chk({tag, "_busy_cycles"}, nbusy, NPAIR);
        check_result(tag, eq, first, cnt);
        @(negedge clk);
        chk({tag, "_done_one_cycle"}, int'(done), 0);
    endtask

    initial begin
        int done_at[$];
        int ndone;

        #1 rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("reset_busy", int'(busy), 0);
        chk("reset_done", int'(done), 0);
        check_result("reset", 0, 0, 0);
        rst = 1'b0;
        @(negedge clk);

        run_one("equal_words", 8'hA5, 8'hA5, 1, 0, 0);
        run_one("low_pair",    8'hA5, 8'hA4, 0, 0, 1);
        run_one("high_pair",   8'hFF, 8'h7F, 0, 3, 1);
        run_one("all_pairs",   8'hFF, 8'h00, 0, 0, 4);

        // start held for 12 edges; operands change after capture.
        @(negedge clk);
        start = 1'b1;
        a = 8'hA5;
        b = 8'hA4;
        for (int k = 1; k <= 18; k++) begin
            @(negedge clk);
            if (k == 1) begin
                a = 8'h00;
                b = 8'hFF;
            end
            if (k == 12) start = 1'b0;
            if (done) begin
                done_at.push_back(k);
                if (k == 5) check_result("b2b_first", 0, 0, 1);
                if (k == 10) check_result("b2b_second", 0, 0, 4);
            end
        end
        chk("b2b_done_count", done_at.size(), 3);
        if (done_at.size() == 3) begin
            chk("b2b_done_first", done_at[0], 5);
            chk("b2b_gap1", done_at[1] - done_at[0], NPAIR + 1);
            chk("b2b_gap2", done_at[2] - done_at[1], NPAIR + 1);
        end

        // Async reset in the middle of RUN, away from any clock edge.
        @(negedge clk);
        start = 1'b1;
        a = 8'h5A;
        b = 8'hA5;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("pre_reset_busy", int'(busy), 1);
        #2 rst = 1'b1;
        #1;
        chk("midrun_rst_busy", int'(busy), 0);
        chk("midrun_rst_done", int'(done), 0);
        check_result("midrun_rst", 0, 0, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        ndone = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (done) ndone = ndone + 1;
        end
        chk("no_done_after_abort", ndone, 0);

        run_one("post_reset", 8'hA5, 8'hA4, 0, 0, 1);

        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
